fetch_sequencer: RTL and testbench

Holds the multicycle processor's architectural stage register, program counter and instruction register. Drives the 3-bit stage and the 6-bit opcode into the control unit. Consumes that unit's next_state, PC_src and j_src to advance the stage and select the next PC. Issues instruction-memory fetches with a ready handshake and stalls in IF until data returns.

---
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Stage register, PC and instruction register for a multicycle core.
// Fetches from instruction memory, waiting in IF until the memory returns data.
module fetch_sequencer #(
  parameter int                ADDR_W        = 32,
  parameter int                INSTR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter int                FETCH_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         next_state,
  input  logic [1:0]         PC_src,
  input  logic               j_src,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  ret_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [2:0]         state,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [31:0]        retired,
  output logic               illegal_state,
  output logic               fetch_timeout
);

  localparam logic [2:0] S_IF  = 3'b000;
  localparam logic [2:0] S_ID  = 3'b001;
  localparam logic [2:0] S_EX  = 3'b010;
  localparam logic [2:0] S_MEM = 3'b011;
  localparam logic [2:0] S_WB  = 3'b100;

  localparam logic [7:0]        TIMEOUT_CNT = 8'(FETCH_TIMEOUT);
  localparam logic [ADDR_W-1:0] PC_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        retired_q, retired_d;
  logic [7:0]         wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_sel;
  logic               ns_legal;

  // Fetch handshake: imem_req is high for every IF cycle and the address is
  // the PC; a word is consumed only on a cycle where imem_req and imem_ready
  // are both high. imem_ready in any other stage is ignored.
  assign imem_req      = (state_q == S_IF);
  assign imem_addr     = pc_q;
  assign state         = state_q;
  assign pc            = pc_q;
  assign pc_plus1      = pc_inc;
  assign instr         = instr_q;
  assign opcode        = instr_q[INSTR_W-1 -: 6];
  assign retired       = retired_q;
  assign illegal_state = illegal_q;
  assign fetch_timeout = timeout_q;

  assign pc_inc   = pc_q + PC_ONE;
  assign ns_legal = (next_state <= S_WB);

  always_comb begin
    pc_sel = pc_inc;
    case (PC_src)
      2'b01:   pc_sel = j_src ? ret_addr : jump_target;
      2'b10:   pc_sel = branch_target;
      default: pc_sel = pc_inc;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    illegal_d = 1'b0;
    timeout_d = timeout_q;

    if (state_q > S_WB) begin
      // Corrupted stage register: resume fetching without touching pc/instr.
      state_d   = S_IF;
      illegal_d = 1'b1;
    end else if (state_q == S_IF) begin
      if (imem_ready) begin
        instr_d = imem_rdata;
        wait_d  = 8'd0;
        if (ns_legal) begin
          state_d = next_state;
        end else begin
          state_d   = S_IF;
          illegal_d = 1'b1;
        end
      end else begin
        if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
        if (wait_d >= TIMEOUT_CNT) timeout_d = 1'b1;
      end
    end else if (!ns_legal) begin
      // A bogus next stage ends the instruction as a plain fall-through.
      state_d   = S_IF;
      illegal_d = 1'b1;
      pc_d      = pc_inc;
      retired_d = retired_q + 32'd1;
    end else begin
      state_d = next_state;
      if (next_state == S_IF) begin
        pc_d      = pc_sel;
        retired_d = retired_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= 32'd0;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Stage encodings kept for reference by bound checkers.
  logic unused_enc;
  assign unused_enc = ^{S_ID, S_EX, S_MEM};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, fetch-timeout sequence,
// then randomized cycles checked against a behavioural model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  next_state;
  logic [1:0]  PC_src;
  logic        j_src;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] ret_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] retired;
  logic        illegal_state;
  logic        fetch_timeout;

  fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .next_state   (next_state),
    .PC_src       (PC_src),
    .j_src        (j_src),
    .jump_target  (jump_target),
    .branch_target(branch_target),
    .ret_addr     (ret_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .state        (state),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .instr        (instr),
    .opcode       (opcode),
    .retired      (retired),
    .illegal_state(illegal_state),
    .fetch_timeout(fetch_timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  ns;
    logic [1:0]  src;
    logic        j;
    logic [31:0] jt;
    logic [31:0] bt;
    logic [31:0] ra;
    logic        rdy;
    logic [31:0] rd;
    logic [2:0]  e_state;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_ret;
    logic        e_ill;
  } vec_t;

  function automatic vec_t mk(logic r, logic [2:0] ns, logic [1:0] src, logic j,
                              logic [31:0] jt, logic [31:0] bt, logic [31:0] ra,
                              logic rdy, logic [31:0] rd, logic [2:0] es,
                              logic [31:0] epc, logic [31:0] ei, logic [31:0] er,
                              logic eill);
    vec_t v;
    v.rst = r; v.ns = ns; v.src = src; v.j = j; v.jt = jt; v.bt = bt; v.ra = ra;
    v.rdy = rdy; v.rd = rd; v.e_state = es; v.e_pc = epc; v.e_instr = ei;
    v.e_ret = er; v.e_ill = eill;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(logic r, logic [2:0] ns, logic [1:0] src, logic j,
                       logic [31:0] jt, logic [31:0] bt, logic [31:0] ra,
                       logic rdy, logic [31:0] rd);
    rst = r; next_state = ns; PC_src = src; j_src = j;
    jump_target = jt; branch_target = bt; ret_addr = ra;
    imem_ready = rdy; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cmp(string tag, string field, logic [31:0] got, logic [31:0] exp);
    if (got !== exp) begin
      $display("FAIL %s %s: got %0h want %0h", tag, field, got, exp);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check(string tag, logic [2:0] es, logic [31:0] epc, logic [31:0] ei,
                       logic [31:0] er, logic eill, logic eto);
    bit bad;
    logic [31:0] epc1;
    epc1 = epc + 32'd1;
    bad = 1'b0;
    bad |= cmp(tag, "state",     {29'd0, state},        {29'd0, es});
    bad |= cmp(tag, "pc",        pc,                    epc);
    bad |= cmp(tag, "imem_addr", imem_addr,             epc);
    bad |= cmp(tag, "imem_req",  {31'd0, imem_req},     {31'd0, (es == 3'd0)});
    bad |= cmp(tag, "pc_plus1",  pc_plus1,              epc1);
    bad |= cmp(tag, "instr",     instr,                 ei);
    bad |= cmp(tag, "opcode",    {26'd0, opcode},       {26'd0, ei[31:26]});
    bad |= cmp(tag, "retired",   retired,               er);
    bad |= cmp(tag, "illegal",   {31'd0, illegal_state}, {31'd0, eill});
    bad |= cmp(tag, "timeout",   {31'd0, fetch_timeout}, {31'd0, eto});
    n_vec++;
    if (bad) n_bad++;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_stage;
  logic [31:0] m_pc, m_instr, m_ret;
  int          m_waits;
  logic        m_ill, m_to;

  task automatic model_step(logic r, logic [2:0] ns, logic [1:0] src, logic j,
                            logic [31:0] jt, logic [31:0] bt, logic [31:0] ra,
                            logic rdy, logic [31:0] rd);
    int want;
    want = int'(ns);
    m_ill = 1'b0;
    if (r) begin
      m_stage = 0; m_pc = 0; m_instr = 0; m_ret = 0; m_waits = 0; m_to = 0;
    end else if (m_stage == 0) begin
      if (rdy) begin
        m_instr = rd;
        m_waits = 0;
        if (want > 4) begin m_stage = 0; m_ill = 1'b1; end
        else m_stage = want;
      end else begin
        m_waits = (m_waits >= 255) ? 255 : m_waits + 1;
        if (m_waits >= 255) m_to = 1'b1;
      end
    end else if (want > 4) begin
      m_stage = 0; m_ill = 1'b1; m_pc = m_pc + 1; m_ret = m_ret + 1;
    end else begin
      if (want == 0) begin
        if (src == 2'b01)      m_pc = j ? ra : jt;
        else if (src == 2'b10) m_pc = bt;
        else                   m_pc = m_pc + 1;
        m_ret = m_ret + 1;
      end
      m_stage = want;
    end
  endtask

  // ---------------- scoreboard ----------------
  localparam int EW = 3 + 32 + 32 + 32 + 2;
  logic [EW-1:0] exp_q[$];

  vec_t tbl[31];

  initial begin
    logic [EW-1:0] e;
    logic [2:0]  ns;
    logic [1:0]  src;
    logic        j, rdy, r;
    logic [31:0] jt, bt, ra, rd;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h0C000001,       1, 0, 32'h0C000001, 0, 0);
    tbl[2]  = mk(0, 2, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,       2, 0, 32'h0C000001, 0, 0);
    tbl[3]  = mk(0, 4, 0, 0, 0, 0, 0, 0, 0,                  4, 0, 32'h0C000001, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 1, 32'h0C000001, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h12345678,       0, 1, 32'h0C000001, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h12345678,       0, 1, 32'h0C000001, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h12345678,       0, 1, 32'h0C000001, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h12345678,       0, 1, 32'h0C000001, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h30000005,       1, 1, 32'h30000005, 1, 0);
    tbl[10] = mk(0, 0, 1, 0, 32'h40, 32'h77, 32'h99, 0, 0,   0, 32'h40, 32'h30000005, 2, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h08000040,       1, 32'h40, 32'h08000040, 2, 0);
    tbl[12] = mk(0, 2, 0, 0, 0, 0, 0, 0, 0,                  2, 32'h40, 32'h08000040, 2, 0);
    tbl[13] = mk(0, 3, 0, 0, 0, 0, 0, 0, 0,                  3, 32'h40, 32'h08000040, 2, 0);
    tbl[14] = mk(0, 0, 1, 1, 32'h999, 32'h88, 32'h1234, 0, 0, 0, 32'h1234, 32'h08000040, 3, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h11111111,       1, 32'h1234, 32'h11111111, 3, 0);
    tbl[16] = mk(0, 2, 0, 0, 0, 0, 0, 0, 0,                  2, 32'h1234, 32'h11111111, 3, 0);
    tbl[17] = mk(0, 0, 2, 0, 32'h999, 32'h80, 32'h555, 0, 0, 0, 32'h80, 32'h11111111, 4, 0);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h22222222,       1, 32'h80, 32'h22222222, 4, 0);
    tbl[19] = mk(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,       0, 32'hFFFFFFFF, 32'h22222222, 5, 0);
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h33333333,       1, 32'hFFFFFFFF, 32'h33333333, 5, 0);
    tbl[21] = mk(0, 0, 3, 1, 32'h7, 32'h8, 32'h9, 0, 0,      0, 0, 32'h33333333, 6, 0);
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h44444444,       1, 0, 32'h44444444, 6, 0);
    tbl[23] = mk(0, 0, 1, 0, 32'h5, 0, 0, 0, 0,              0, 5, 32'h44444444, 7, 0);
    tbl[24] = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h55555555,       1, 5, 32'h55555555, 7, 0);
    tbl[25] = mk(0, 2, 0, 0, 0, 0, 0, 0, 0,                  2, 5, 32'h55555555, 7, 0);
    tbl[26] = mk(0, 6, 2, 0, 0, 32'h80, 0, 0, 0,             0, 6, 32'h55555555, 8, 1);
    tbl[27] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,                  0, 6, 32'h55555555, 8, 0);
    tbl[28] = mk(0, 1, 0, 0, 0, 0, 0, 1, 32'h66666666,       1, 6, 32'h66666666, 8, 0);
    tbl[29] = mk(0, 2, 0, 0, 0, 0, 0, 0, 0,                  2, 6, 32'h66666666, 8, 0);
    tbl[30] = mk(1, 0, 2, 0, 0, 32'h80, 0, 1, 32'hFFFFFFFF,  0, 0, 0, 0, 0);

    // Directed vector table
    for (int i = 0; i < 31; i++) begin
      drive(tbl[i].rst, tbl[i].ns, tbl[i].src, tbl[i].j, tbl[i].jt, tbl[i].bt,
            tbl[i].ra, tbl[i].rdy, tbl[i].rd);
      tick();
      check($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_pc, tbl[i].e_instr,
            tbl[i].e_ret, tbl[i].e_ill, 1'b0);
    end

    // Fetch timeout: 254 idle cycles stay quiet, the 255th raises the flag
    for (int i = 0; i < 254; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h0BAD0BAD);
      tick();
      check("to_wait", 0, 0, 0, 0, 0, 0);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 32'h0BAD0BAD);
    tick();
    check("to_hit", 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 32'hABCDEF01);
    tick();
    check("to_sticky_id", 1, 0, 32'hABCDEF01, 0, 0, 1);
    drive(0, 2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("to_sticky_ex", 2, 0, 32'hABCDEF01, 0, 0, 1);
    drive(1, 0, 1, 1, 32'h40, 32'h80, 32'h1234, 1, 32'h1);
    tick();
    check("rst_in_ex", 0, 0, 0, 0, 0, 0);

    // Randomized cycles against the behavioural model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      src = 2'($urandom_range(0, 3));
      j   = 1'($urandom_range(0, 1));
      jt  = $urandom;
      bt  = $urandom;
      ra  = $urandom;
      rd  = $urandom;
      if ($urandom_range(0, 19) == 0) ns = 3'($urandom_range(5, 7));
      else if (m_stage == 0)          ns = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd1;
      else                            ns = 3'($urandom_range(0, 4));
      drive(r, ns, src, j, jt, bt, ra, rdy, rd);
      model_step(r, ns, src, j, jt, bt, ra, rdy, rd);
      exp_q.push_back({3'(m_stage), m_pc, m_instr, m_ret, m_ill, m_to});
      tick();
      e = exp_q.pop_front();
      check($sformatf("rnd%0d", i), e[EW-1 -: 3], e[EW-4 -: 32], e[EW-36 -: 32],
            e[EW-68 -: 32], e[1], e[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
